draw_scheduler: RTL and testbench
=================================

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 The block SHALL have the following parameters:
  WIDTH, 8, coordinate width.
  COLOUR_WIDTH, 3, colour width.
  OPCODE_WIDTH, 3, opcode width.
  DEPTH, 4, command queue entries (power of two, at least 2).
REQ-002 The block SHALL have the following ports:
  clock  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high.
  cmd_valid  in  1  command offered.
  cmd_ready  out  1  queue can accept.
  cmd_opcode  in  OPCODE_WIDTH  command opcode.
  cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy  in  WIDTH each  vertex operands.
  cmd_colour  in  COLOUR_WIDTH  fill colour.
  cmd_error  out  1  one-cycle pulse: illegal opcode dropped.
  opcode  out  OPCODE_WIDTH  to draw engine.
  ax, ay, bx, by, cx, cy  out  WIDTH each  to draw engine.
  colour  out  COLOUR_WIDTH  to draw engine.
  draw_en  out  1  draw engine enable (level).
  draw_done  in  1  from draw engine.
  busy  out  1  queue non-empty or engine active.
  done_count  out  16  completed commands, wraps.

Function
REQ-003 A command SHALL be transferred on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-004 cmd_ready SHALL equal "queue not full"; there is no bypass, so no push occurs while full, even on a cycle that pops.
REQ-005 Legal opcodes SHALL be 0 (CLEAR) and 1 (TRIANGLE); a transferred command with any other opcode SHALL NOT be enqueued, and cmd_error SHALL be high for exactly the following cycle.
REQ-006 The queue SHALL be FIFO-ordered, and simultaneous push and pop when not full SHALL keep the occupancy unchanged.
REQ-007 The FSM SHALL have the states IDLE, RUN and RELEASE.
REQ-008 In IDLE with the queue non-empty, the next edge SHALL pop the head into the output registers, set draw_en=1 and enter RUN.
REQ-009 Latency: a command pushed at edge E into an empty queue with the FSM in IDLE SHALL have draw_en=1 after edge E+1.
REQ-010 In RUN, draw_en SHALL be held high, and opcode, operands and colour SHALL be held stable, until draw_done is sampled high.
REQ-011 On the edge where draw_done is sampled high in RUN, the block SHALL set draw_en=0, increment done_count (modulo 2^16) and enter RELEASE.
REQ-012 RELEASE SHALL persist until draw_done is sampled low, then enter IDLE, giving a minimum of one draw_en-low cycle between commands.
REQ-013 draw_done while in IDLE or RELEASE SHALL NOT change done_count.
REQ-014 busy SHALL equal (queue non-empty) OR (state is not IDLE).
REQ-015 Output registers SHALL change only on the pop edge in REQ-008.

Reset
REQ-016 Asserting reset SHALL immediately, without waiting for a clock edge, set: state IDLE; queue empty; draw_en=0; cmd_error=0; done_count=0; opcode, operands and colour = 0.
REQ-017 cmd_ready SHALL be 1 from reset onward.
REQ-018 Reset during RUN SHALL abandon the in-flight and queued commands without incrementing done_count.

Structure
REQ-019 The shared package draw_pkg SHALL hold OP_CLEAR=0, OP_TRIANGLE=1, OPCODE_WIDTH and the packed command-word width (OPCODE_WIDTH + 6·WIDTH + COLOUR_WIDTH).
REQ-020 The queue SHALL be the sub-module draw_cmd_fifo (push/pop/full/empty, packed command word), with the FSM and output registers in draw_scheduler.

Verification
REQ-021 Single triangle: push op1, A(10,20), B(50,20), C(30,60), colour 5 -> draw_en high after E+1 with those values; draw_done=1 -> draw_en=0 and done_count=1.
REQ-022 Fill: with draw_done held 0, push 6 commands -> cmd_ready=0 once the queue holds 4 plus 1 in RUN; the remaining push stalls until the first completion.
REQ-023 Ordering: push CLEAR colour 0 then TRIANGLE colour 7 -> they are issued in that order with a draw_en-low gap of at least 1 cycle, and done_count=2.
REQ-024 Illegal opcode: push op3 -> cmd_error pulses for 1 cycle, busy stays 0 and draw_en is never asserted.
REQ-025 Sticky done: hold draw_done high for 3 cycles after completion with the queue non-empty -> the next draw_en waits until draw_done falls, and done_count increments once.
REQ-026 Reset mid-RUN with 2 commands queued -> draw_en=0 asynchronously, busy=0, done_count=0; a fresh push is issued normally.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared constants and types for the draw command scheduler.
// Holds the opcode set, default widths and the FSM state encoding.
package draw_pkg;

  localparam int WIDTH        = 8;
  localparam int COLOUR_WIDTH = 3;
  localparam int OPCODE_WIDTH = 3;
  localparam int CMD_WIDTH    = OPCODE_WIDTH + 6 * WIDTH + COLOUR_WIDTH;

  localparam int OP_CLEAR    = 0;
  localparam int OP_TRIANGLE = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/draw_cmd_fifo.sv
// Command queue for the draw scheduler.
// Power-of-two ring buffer with wrap-bit pointers; head is combinational.
module draw_cmd_fifo
  import draw_pkg::*;
#(
  parameter int W     = CMD_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once pushed.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: rtl/draw_scheduler.sv
// Queues draw commands and hands them one at a time to a draw engine.
// draw_en is a level held until the engine's done handshake completes.
module draw_scheduler #(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int DEPTH        = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_opcode,
  input  logic [WIDTH-1:0]        cmd_ax,
  input  logic [WIDTH-1:0]        cmd_ay,
  input  logic [WIDTH-1:0]        cmd_bx,
  input  logic [WIDTH-1:0]        cmd_by,
  input  logic [WIDTH-1:0]        cmd_cx,
  input  logic [WIDTH-1:0]        cmd_cy,
  input  logic [COLOUR_WIDTH-1:0] cmd_colour,
  output logic                    cmd_error,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [WIDTH-1:0]        ax,
  output logic [WIDTH-1:0]        ay,
  output logic [WIDTH-1:0]        bx,
  output logic [WIDTH-1:0]        by,
  output logic [WIDTH-1:0]        cx,
  output logic [WIDTH-1:0]        cy,
  output logic [COLOUR_WIDTH-1:0] colour,
  output logic                    draw_en,
  input  logic                    draw_done,
  output logic                    busy,
  output logic [15:0]             done_count
);

  import draw_pkg::*;

  localparam int CW = OPCODE_WIDTH + 6 * WIDTH + COLOUR_WIDTH;

  state_t        state;
  state_t        next_state;
  logic          pop;
  logic          finish;
  logic          legal;
  logic          transfer;
  logic          full;
  logic          empty;
  logic [CW-1:0] cmd_word;
  logic [CW-1:0] head;
  logic [CW-1:0] out_word;

  assign cmd_word = {cmd_opcode, cmd_ax, cmd_ay, cmd_bx,
                     cmd_by, cmd_cx, cmd_cy, cmd_colour};

  assign legal = (cmd_opcode == OPCODE_WIDTH'(OP_CLEAR)) ||
                 (cmd_opcode == OPCODE_WIDTH'(OP_TRIANGLE));

  assign cmd_ready = !full;
  assign transfer  = cmd_valid && cmd_ready;

  draw_cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (transfer && legal),
    .pop   (pop),
    .data  (cmd_word),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (draw_done) begin
          finish     = 1'b1;
          next_state = RELEASE;
        end
      end
      RELEASE: begin
        // Wait for the engine to drop done so it is never re-counted.
        if (!draw_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_word   <= '0;
      done_count <= '0;
      cmd_error  <= 1'b0;
    end else begin
      if (pop)    out_word   <= head;
      if (finish) done_count <= done_count + 16'd1;
      cmd_error <= transfer && !legal;
    end
  end

  assign {opcode, ax, ay, bx, by, cx, cy, colour} = out_word;

  assign draw_en = (state == RUN);
  assign busy    = !empty || (state != IDLE);

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed self-checking bench for draw_scheduler.
// Vector table for single commands plus hand-written multi-cycle sequences.
module tb_draw_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [7:0]  cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy;
  logic [2:0]  cmd_colour;
  logic        cmd_error;
  logic [2:0]  opcode;
  logic [7:0]  ax, ay, bx, by, cx, cy;
  logic [2:0]  colour;
  logic        draw_en;
  logic        draw_done;
  logic        busy;
  logic [15:0] done_count;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int min_gap;
  int rec[$];

  typedef struct {
    logic [2:0] op;
    logic [7:0] ax, ay, bx, by, cx, cy;
    logic [2:0] col;
    logic       err;
  } vec_t;

  vec_t vecs[5];

  draw_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_ax     (cmd_ax),
    .cmd_ay     (cmd_ay),
    .cmd_bx     (cmd_bx),
    .cmd_by     (cmd_by),
    .cmd_cx     (cmd_cx),
    .cmd_cy     (cmd_cy),
    .cmd_colour (cmd_colour),
    .cmd_error  (cmd_error),
    .opcode     (opcode),
    .ax         (ax),
    .ay         (ay),
    .bx         (bx),
    .by         (by),
    .cx         (cx),
    .cy         (cy),
    .colour     (colour),
    .draw_en    (draw_en),
    .draw_done  (draw_done),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op,
                              input logic [7:0] a,
                              input logic [2:0] col);
    vec_t v;
    v.op = op; v.ax = a; v.ay = a + 8'd1;
    v.bx = a + 8'd2; v.by = a + 8'd3;
    v.cx = a + 8'd4; v.cy = a + 8'd5;
    v.col = col; v.err = 1'b0;
    return v;
  endfunction

  function automatic logic [63:0] pack(input vec_t v);
    return {10'd0, v.op, v.ax, v.ay, v.bx, v.by, v.cx, v.cy, v.col};
  endfunction

  function automatic logic [63:0] out_word();
    return {10'd0, opcode, ax, ay, bx, by, cx, cy, colour};
  endfunction

  task automatic drive(input vec_t v);
    cmd_opcode = v.op;
    cmd_ax = v.ax; cmd_ay = v.ay;
    cmd_bx = v.bx; cmd_by = v.by;
    cmd_cx = v.cx; cmd_cy = v.cy;
    cmd_colour = v.col;
  endtask

  // Behaves as a draw engine that finishes one cycle after enable.
  task automatic drain(input int n);
    int   got = 0;
    int   gap = 0;
    int   cyc = 0;
    bit   seen = 0;
    logic prev = 1'b0;
    rec.delete();
    min_gap = 1000;
    while (!(got == n && !busy && !draw_en) && cyc < 300) begin
      if (draw_en && !prev) begin
        rec.push_back((int'(opcode) << 16) | (int'(colour) << 8) | int'(ax));
        if (seen && gap < min_gap) min_gap = gap;
        seen = 1; got++; gap = 0;
      end
      if (!draw_en) gap++;
      prev = draw_en;
      draw_done = draw_en;
      tick();
      cyc++;
    end
    draw_done = 1'b0;
    check("drain_timeout", 64'(cyc < 300), 64'd1);
    check("drain_count", 64'(rec.size()), 64'(n));
  endtask

  initial begin
    vecs[0] = '{3'd1, 8'd10, 8'd20, 8'd50, 8'd20, 8'd30, 8'd60, 3'd5, 1'b0};
    vecs[1] = '{3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 3'd0, 1'b0};
    vecs[2] = '{3'd3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 3'd2, 1'b1};
    vecs[3] = '{3'd1, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 3'd7, 1'b0};
    vecs[4] = '{3'd7, 8'hff, 8'h80, 8'h7f, 8'h01, 8'hfe, 8'h02, 3'd7, 1'b1};

    reset = 1'b1;
    cmd_valid = 1'b0;
    draw_done = 1'b0;
    drive(mk(3'd0, 8'd0, 3'd0));
    #2;
    check("rst_draw_en", 64'(draw_en), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_count", 64'(done_count), 64'd0);
    check("rst_cmd_error", 64'(cmd_error), 64'd0);
    check("rst_outputs", out_word(), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tick();

    // Single-command vectors
    for (int i = 0; i < 5; i++) begin
      check("vec_ready", 64'(cmd_ready), 64'd1);
      drive(vecs[i]);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("vec_cmd_error", 64'(cmd_error), 64'(vecs[i].err));
      check("vec_en_at_e", 64'(draw_en), 64'd0);
      if (vecs[i].err) begin
        check("illegal_busy", 64'(busy), 64'd0);
        tick();
        check("illegal_err_pulse", 64'(cmd_error), 64'd0);
        check("illegal_en", 64'(draw_en), 64'd0);
        check("illegal_busy2", 64'(busy), 64'd0);
        check("illegal_done", 64'(done_count), 64'(exp_done));
      end else begin
        check("vec_busy", 64'(busy), 64'd1);
        tick();
        check("vec_en_e1", 64'(draw_en), 64'd1);
        check("vec_word", out_word(), pack(vecs[i]));
        draw_done = 1'b1;
        tick();
        exp_done++;
        check("vec_en_off", 64'(draw_en), 64'd0);
        check("vec_done_count", 64'(done_count), 64'(exp_done));
        draw_done = 1'b0;
        tick();
        check("vec_idle_busy", 64'(busy), 64'd0);
        check("vec_hold_word", out_word(), pack(vecs[i]));
      end
    end

    // Ordering: CLEAR then TRIANGLE with a low gap
    drive(mk(3'd0, 8'h40, 3'd0));
    cmd_valid = 1'b1;
    tick();
    drive(mk(3'd1, 8'h41, 3'd7));
    tick();
    cmd_valid = 1'b0;
    drain(2);
    exp_done += 2;
    check("order_first", 64'(rec[0]), 64'h0_00_40);
    check("order_second", 64'(rec[1]), 64'h1_07_41);
    check("order_gap", 64'(min_gap >= 1), 64'd1);
    check("order_done", 64'(done_count), 64'(exp_done));

    // Fill: engine stalled, queue fills to DEPTH behind one in RUN
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(mk(3'd1, 8'(i), 3'(i)));
      tick();
    end
    check("fill_ready", 64'(cmd_ready), 64'd0);
    check("fill_en", 64'(draw_en), 64'd1);
    check("fill_head", 64'(ax), 64'd0);
    drive(mk(3'd1, 8'd5, 3'd5));
    repeat (2) tick();
    check("fill_stall", 64'(cmd_ready), 64'd0);
    check("fill_stable", 64'(ax), 64'd0);
    draw_done = 1'b1;
    tick();
    exp_done++;
    check("fill_release_ready", 64'(cmd_ready), 64'd0);
    draw_done = 1'b0;
    tick();
    check("fill_idle_ready", 64'(cmd_ready), 64'd0);
    tick();
    check("fill_pop_ready", 64'(cmd_ready), 64'd1);
    check("fill_pop_en", 64'(draw_en), 64'd1);
    tick();
    cmd_valid = 1'b0;
    check("fill_refull", 64'(cmd_ready), 64'd0);
    drain(5);
    exp_done += 5;
    for (int i = 0; i < 5; i++)
      check("fill_order", 64'(rec[i] & 'hff), 64'(i + 1));
    check("fill_done", 64'(done_count), 64'(exp_done));

    // Sticky done: next command waits for draw_done to fall
    cmd_valid = 1'b1;
    drive(mk(3'd1, 8'h11, 3'd1));
    tick();
    drive(mk(3'd1, 8'h22, 3'd2));
    tick();
    cmd_valid = 1'b0;
    check("sticky_run", 64'(ax), 64'h11);
    draw_done = 1'b1;
    tick();
    exp_done++;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sticky_en_low", 64'(draw_en), 64'd0);
      check("sticky_once", 64'(done_count), 64'(exp_done));
    end
    draw_done = 1'b0;
    tick();
    check("sticky_idle_en", 64'(draw_en), 64'd0);
    tick();
    check("sticky_next_en", 64'(draw_en), 64'd1);
    check("sticky_next_ax", 64'(ax), 64'h22);
    draw_done = 1'b1;
    tick();
    exp_done++;
    draw_done = 1'b0;
    tick();
    check("sticky_done", 64'(done_count), 64'(exp_done));

    // Reset mid-RUN with two queued
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(mk(3'd1, 8'(8'h30 + i), 3'd3));
      tick();
    end
    cmd_valid = 1'b0;
    check("pre_rst_en", 64'(draw_en), 64'd1);
    reset = 1'b1;
    #2;
    exp_done = 0;
    check("arst_en", 64'(draw_en), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done_count), 64'd0);
    check("arst_word", out_word(), 64'd0);
    check("arst_ready", 64'(cmd_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("post_rst_busy", 64'(busy), 64'd0);
    drive(mk(3'd1, 8'h77, 3'd6));
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("fresh_en", 64'(draw_en), 64'd1);
    check("fresh_word", out_word(), pack(mk(3'd1, 8'h77, 3'd6)));
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    tick();
    check("fresh_done", 64'(done_count), 64'd1);
    check("fresh_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
